// File: rtl/tick_gen_prog.sv
// ============================================================================
// tick_gen_prog -- runtime-programmable timebase generator
//
// Generates single-cycle clock-enable pulses for logic that stays on clk:
//   tick       once per main period (div_reg enabled cycles)
//   half_tick  at the mid-period point (after half = div_reg >> 1 cycles)
//   sq_out     registered square wave, low for the first half, high for the
//              remainder of the period (odd divisor -> high phase one longer)
//   scan_tick  once every SCAN_DIV enabled cycles, independent of the divisor
//
// The main divisor can be rewritten at runtime. A write is held as pending
// and only takes effect on a period boundary (or immediately on the next
// edge while counting is disabled), so the outputs never see a truncated
// or stretched period. div_ack marks the edge where the new value lands.
//
// Ports
//   clk        in   1      system clock, posedge
//   reset      in   1      asynchronous active-low reset
//   en         in   1      count enable; 0 freezes counters, suppresses pulses
//   div_wr     in   1      strobe: capture div_in as the next divisor
//   div_in     in   CNT_W  requested divisor (values below 2 clamp to 2)
//   div_ack    out  1      pulse when a pending divisor is applied
//   tick       out  1      main period pulse
//   half_tick  out  1      mid-period pulse
//   sq_out     out  1      square wave
//   scan_tick  out  1      scan period pulse
//   cnt        out  CNT_W  current main counter value
// ============================================================================
module tick_gen_prog #(
    parameter int CNT_W       = 26,
    parameter int DIV_DEFAULT = 50_000_000,
    parameter int SCAN_W      = 16,
    parameter int SCAN_DIV    = 50_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             div_wr,
    input  logic [CNT_W-1:0] div_in,
    output logic             div_ack,
    output logic             tick,
    output logic             half_tick,
    output logic             sq_out,
    output logic             scan_tick,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0]  DIV_RST   = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0]  DIV_MIN   = CNT_W'(2);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(1);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [CNT_W-1:0]   div_reg_q,   div_reg_d;
    logic [CNT_W-1:0]   pend_val_q,  pend_val_d;
    logic [SCAN_W-1:0]  scan_cnt_q,  scan_cnt_d;
    logic               tick_q,      tick_d;
    logic               half_tick_q, half_tick_d;
    logic               sq_q,        sq_d;
    logic               scan_tick_q, scan_tick_d;
    logic               div_ack_q,   div_ack_d;

    // ------------------------------------------------------------------
    // Decodes of the current count
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] half_val;
    logic             at_wrap;
    logic             at_half;
    logic             apply_ok;
    logic [CNT_W-1:0] div_in_clamped;

    assign half_val       = div_reg_q >> 1;
    assign at_wrap        = (cnt_q == (div_reg_q - CNT_ONE));
    assign at_half        = (cnt_q == (half_val - CNT_ONE));
    assign div_in_clamped = (div_in < DIV_MIN) ? DIV_MIN : div_in;

    // A fresh write on the same edge wins over applying the older pending
    // value: the new value is captured and the apply waits for the next
    // opportunity, so a write never lands mid-period.
    assign apply_ok = (state_q == ST_PENDING) && !div_wr;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_reg_d   = div_reg_q;
        pend_val_d  = pend_val_q;
        scan_cnt_d  = scan_cnt_q;
        sq_d        = sq_q;
        tick_d      = 1'b0;
        half_tick_d = 1'b0;
        scan_tick_d = 1'b0;
        div_ack_d   = 1'b0;

        if (en) begin
            // Main counter. The wrap test comes first so that a divisor of 2
            // (half-1 == 0, wrap at 1) and every other divisor decode cleanly.
            if (at_wrap) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                sq_d   = 1'b0;
                // The wrap itself used the old divisor; the next period
                // starts with the pending one.
                if (apply_ok) begin
                    div_reg_d = pend_val_q;
                    div_ack_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end else if (at_half) begin
                cnt_d       = cnt_q + CNT_ONE;
                half_tick_d = 1'b1;
                sq_d        = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end

            // Scan counter runs on its own fixed period.
            if (scan_cnt_q == SCAN_LAST) begin
                scan_cnt_d  = '0;
                scan_tick_d = 1'b1;
            end else begin
                scan_cnt_d = scan_cnt_q + SCAN_ONE;
            end
        end else begin
            // Counting is frozen, so there is no period to protect: apply a
            // pending divisor straight away and restart the period cleanly.
            if (apply_ok) begin
                div_reg_d = pend_val_q;
                cnt_d     = '0;
                sq_d      = 1'b0;
                div_ack_d = 1'b1;
                state_d   = ST_IDLE;
            end
        end

        // Capture overrides any apply decided above for the pending state.
        if (div_wr) begin
            pend_val_d = div_in_clamped;
            state_d    = ST_PENDING;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            div_reg_q   <= DIV_RST;
            pend_val_q  <= '0;
            scan_cnt_q  <= '0;
            tick_q      <= 1'b0;
            half_tick_q <= 1'b0;
            sq_q        <= 1'b0;
            scan_tick_q <= 1'b0;
            div_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_reg_q   <= div_reg_d;
            pend_val_q  <= pend_val_d;
            scan_cnt_q  <= scan_cnt_d;
            tick_q      <= tick_d;
            half_tick_q <= half_tick_d;
            sq_q        <= sq_d;
            scan_tick_q <= scan_tick_d;
            div_ack_q   <= div_ack_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all straight from flops)
    // ------------------------------------------------------------------
    assign cnt       = cnt_q;
    assign tick      = tick_q;
    assign half_tick = half_tick_q;
    assign sq_out    = sq_q;
    assign scan_tick = scan_tick_q;
    assign div_ack   = div_ack_q;

endmodule

// File: tb/tb_tick_gen_prog.sv
// ============================================================================
// tb_tick_gen_prog -- directed self-checking bench for tick_gen_prog
// Configuration: CNT_W=8, DIV_DEFAULT=10, SCAN_W=4, SCAN_DIV=4.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point,
// after the edge's register updates have settled.
// ============================================================================
`timescale 1ns/1ps
module tb_tick_gen_prog;

    logic       clk;
    logic       reset;
    logic       en;
    logic       div_wr;
    logic [7:0] div_in;
    logic       div_ack;
    logic       tick;
    logic       half_tick;
    logic       sq_out;
    logic       scan_tick;
    logic [7:0] cnt;

    int tests_run = 0;
    int tests_failed = 0;

    tick_gen_prog #(
        .CNT_W(8), .DIV_DEFAULT(10), .SCAN_W(4), .SCAN_DIV(4)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .div_wr(div_wr), .div_in(div_in),
        .div_ack(div_ack), .tick(tick), .half_tick(half_tick), .sq_out(sq_out),
        .scan_tick(scan_tick), .cnt(cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        en     = 1'b0;
        div_wr = 1'b0;
        div_in = 8'd0;
        step();
        step();
        reset = 1'b1;
    endtask

    // Scenario 1: reset values, then default period 10 with sq 5 low / 5 high.
    task automatic test_reset();
        logic [7:0] exp_cnt;
        reset  = 1'b0;
        en     = 1'b1;
        div_wr = 1'b0;
        div_in = 8'd0;
        step();
        step();
        tests_run++;
        if ({tick, half_tick, sq_out, scan_tick, div_ack} !== 5'b0 || cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_state: outs=%b cnt=%0d required outs=00000 cnt=0",
                     {tick, half_tick, sq_out, scan_tick, div_ack}, cnt);
        end
        reset = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            step();
            exp_cnt = 8'(e % 10);
            tests_run++;
            if (cnt !== exp_cnt || tick !== (e % 10 == 0) || half_tick !== (e % 10 == 5)
                || sq_out !== (e % 10 >= 5) || scan_tick !== (e % 4 == 0) || div_ack !== 1'b0) begin
                tests_failed++;
                $display("FAIL default_period edge %0d: cnt=%0d t=%b h=%b sq=%b sc=%b ack=%b required cnt=%0d t=%b h=%b sq=%b sc=%b ack=0",
                         e, cnt, tick, half_tick, sq_out, scan_tick, div_ack, exp_cnt,
                         (e % 10 == 0), (e % 10 == 5), (e % 10 >= 5), (e % 4 == 0));
            end
        end
        $display("[TB] test_reset done");
    endtask

    // Scenario 2: write 7 at cnt=3; applied on the edge-10 wrap.
    task automatic test_div_change();
        int rel;
        do_reset();
        en = 1'b1;
        for (int e = 1; e <= 3; e++) step();
        tests_run++;
        if (cnt !== 8'd3) begin
            tests_failed++;
            $display("FAIL div7_precnt: cnt=%0d required 3", cnt);
        end
        div_wr = 1'b1;
        div_in = 8'd7;
        for (int e = 4; e <= 10; e++) begin
            step();
            div_wr = 1'b0;
            tests_run++;
            if (tick !== (e == 10) || div_ack !== (e == 10) || half_tick !== (e == 5)) begin
                tests_failed++;
                $display("FAIL div7_old_period edge %0d: t=%b ack=%b h=%b required t=%b ack=%b h=%b",
                         e, tick, div_ack, half_tick, (e == 10), (e == 10), (e == 5));
            end
        end
        for (int e = 11; e <= 31; e++) begin
            step();
            rel = (e - 10) % 7;
            tests_run++;
            if (cnt !== 8'(rel) || tick !== (rel == 0) || half_tick !== (rel == 3)
                || sq_out !== (rel >= 3) || div_ack !== 1'b0) begin
                tests_failed++;
                $display("FAIL div7_new_period edge %0d: cnt=%0d t=%b h=%b sq=%b ack=%b required cnt=%0d t=%b h=%b sq=%b ack=0",
                         e, cnt, tick, half_tick, sq_out, div_ack, rel, (rel == 0), (rel == 3), (rel >= 3));
            end
        end
        $display("[TB] test_div_change done");
    endtask

    // Scenario 3: divisors 1 and 0 both clamp to 2.
    task automatic test_clamp();
        int acks;
        do_reset();
        en     = 1'b1;
        div_wr = 1'b1;
        div_in = 8'd1;
        step();
        div_wr = 1'b0;
        for (int e = 2; e <= 9; e++) step();
        step();
        tests_run++;
        if (tick !== 1'b1 || div_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL clamp1_apply: t=%b ack=%b required t=1 ack=1", tick, div_ack);
        end
        for (int r = 1; r <= 6; r++) begin
            step();
            tests_run++;
            if (cnt !== 8'(r % 2) || tick !== (r % 2 == 0) || half_tick !== (r % 2 == 1)
                || sq_out !== (r % 2 == 1) || div_ack !== 1'b0) begin
                tests_failed++;
                $display("FAIL clamp1_period rel %0d: cnt=%0d t=%b h=%b sq=%b ack=%b required cnt=%0d t=%b h=%b sq=%b ack=0",
                         r, cnt, tick, half_tick, sq_out, div_ack, r % 2, (r % 2 == 0), (r % 2 == 1), (r % 2 == 1));
            end
        end
        div_wr = 1'b1;
        div_in = 8'd0;
        acks = 0;
        for (int r = 7; r <= 12; r++) begin
            step();
            div_wr = 1'b0;
            if (div_ack === 1'b1) acks++;
            tests_run++;
            if (cnt !== 8'(r % 2) || tick !== (r % 2 == 0) || sq_out !== (r % 2 == 1)
                || div_ack !== (r == 8)) begin
                tests_failed++;
                $display("FAIL clamp0_period rel %0d: cnt=%0d t=%b sq=%b ack=%b required cnt=%0d t=%b sq=%b ack=%b",
                         r, cnt, tick, sq_out, div_ack, r % 2, (r % 2 == 0), (r % 2 == 1), (r == 8));
            end
        end
        tests_run++;
        if (acks !== 1) begin
            tests_failed++;
            $display("FAIL clamp0_ack_count: acks=%0d required 1", acks);
        end
        $display("[TB] test_clamp done");
    endtask

    // Scenario 4: freeze at cnt=6, resume, then write 12 while disabled.
    task automatic test_enable();
        do_reset();
        en = 1'b1;
        for (int e = 1; e <= 6; e++) step();
        en = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            step();
            tests_run++;
            if (cnt !== 8'd6 || sq_out !== 1'b1 || {tick, half_tick, scan_tick, div_ack} !== 4'b0) begin
                tests_failed++;
                $display("FAIL freeze cycle %0d: cnt=%0d sq=%b pulses=%b required cnt=6 sq=1 pulses=0000",
                         e, cnt, sq_out, {tick, half_tick, scan_tick, div_ack});
            end
        end
        en = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            tests_run++;
            if (cnt !== 8'((6 + e) % 10) || tick !== (e == 4)) begin
                tests_failed++;
                $display("FAIL resume edge %0d: cnt=%0d t=%b required cnt=%0d t=%b",
                         e, cnt, tick, (6 + e) % 10, (e == 4));
            end
        end
        step();
        step();
        en     = 1'b0;
        div_wr = 1'b1;
        div_in = 8'd12;
        step();
        div_wr = 1'b0;
        tests_run++;
        if (cnt !== 8'd2 || div_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr12_capture: cnt=%0d ack=%b required cnt=2 ack=0", cnt, div_ack);
        end
        step();
        tests_run++;
        if (cnt !== 8'd0 || div_ack !== 1'b1 || sq_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr12_apply: cnt=%0d ack=%b sq=%b required cnt=0 ack=1 sq=0", cnt, div_ack, sq_out);
        end
        step();
        tests_run++;
        if (div_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr12_ack_single: ack=%b required 0", div_ack);
        end
        en = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step();
            tests_run++;
            if (cnt !== 8'(e % 12) || tick !== (e == 12) || half_tick !== (e == 6)
                || sq_out !== (e >= 6 && e < 12)) begin
                tests_failed++;
                $display("FAIL div12_period edge %0d: cnt=%0d t=%b h=%b sq=%b required cnt=%0d t=%b h=%b sq=%b",
                         e, cnt, tick, half_tick, sq_out, e % 12, (e == 12), (e == 6), (e >= 6 && e < 12));
            end
        end
        $display("[TB] test_enable done");
    endtask

    // Scenario 5: async reset with a write pending discards the write.
    task automatic test_async_reset();
        do_reset();
        en = 1'b1;
        for (int e = 1; e <= 6; e++) step();
        div_wr = 1'b1;
        div_in = 8'd5;
        step();
        div_wr = 1'b0;
        tests_run++;
        if (cnt !== 8'd7 || sq_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL prereset: cnt=%0d sq=%b required cnt=7 sq=1", cnt, sq_out);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (cnt !== 8'd0 || {tick, half_tick, sq_out, scan_tick, div_ack} !== 5'b0) begin
            tests_failed++;
            $display("FAIL async_reset: cnt=%0d outs=%b required cnt=0 outs=00000",
                     cnt, {tick, half_tick, sq_out, scan_tick, div_ack});
        end
        step();
        reset = 1'b1;
        for (int e = 1; e <= 21; e++) begin
            step();
            tests_run++;
            if (tick !== (e % 10 == 0) || div_ack !== 1'b0 || cnt !== 8'(e % 10)) begin
                tests_failed++;
                $display("FAIL postreset edge %0d: cnt=%0d t=%b ack=%b required cnt=%0d t=%b ack=0",
                         e, cnt, tick, div_ack, e % 10, (e % 10 == 0));
            end
        end
        $display("[TB] test_async_reset done");
    endtask

    // Scenario 6: scan_tick across a divisor change, then back-to-back writes.
    task automatic test_back_to_back();
        logic exp_tick;
        int   acks;
        do_reset();
        en = 1'b1;
        step();
        div_wr = 1'b1;
        div_in = 8'd3;
        step();
        div_wr = 1'b0;
        for (int e = 3; e <= 20; e++) begin
            step();
            exp_tick = (e == 10 || e == 13 || e == 16 || e == 19);
            tests_run++;
            if (scan_tick !== (e % 4 == 0) || tick !== exp_tick || div_ack !== (e == 10)) begin
                tests_failed++;
                $display("FAIL scan_div3 edge %0d: sc=%b t=%b ack=%b required sc=%b t=%b ack=%b",
                         e, scan_tick, tick, div_ack, (e % 4 == 0), exp_tick, (e == 10));
            end
        end
        acks = 0;
        div_wr = 1'b1;
        div_in = 8'd6;
        for (int e = 21; e <= 45; e++) begin
            step();
            if (e == 21) begin
                div_in = 8'd8;
            end else begin
                div_wr = 1'b0;
            end
            if (div_ack === 1'b1) acks++;
            exp_tick = (e == 22 || e == 25 || e == 33 || e == 41);
            tests_run++;
            if (tick !== exp_tick || div_ack !== (e == 25) || scan_tick !== (e % 4 == 0)) begin
                tests_failed++;
                $display("FAIL b2b edge %0d: t=%b ack=%b sc=%b required t=%b ack=%b sc=%b",
                         e, tick, div_ack, scan_tick, exp_tick, (e == 25), (e % 4 == 0));
            end
        end
        tests_run++;
        if (acks !== 1) begin
            tests_failed++;
            $display("FAIL b2b_ack_count: acks=%0d required 1", acks);
        end
        $display("[TB] test_back_to_back done");
    endtask

    initial begin
        reset  = 1'b0;
        en     = 1'b0;
        div_wr = 1'b0;
        div_in = 8'd0;
        test_reset();
        test_div_change();
        test_clamp();
        test_enable();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
